// File: rtl/serial_sub4.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub4
// Purpose  : Bit-serial subtractor, d = a - b - bin, LSB first, one bit per
//            clock, with a start/done handshake. Inverse companion of the
//            4-bit ripple adder.
// Ports    : clk      rising-edge clock
//            rst      asynchronous active-high reset
//            start_i  request, ignored while busy_o=1
//            a_i      minuend (unsigned), captured on accepted start
//            b_i      subtrahend (unsigned), captured on accepted start
//            bin_i    borrow-in, captured on accepted start
//            busy_o   high while an operation is running
//            done_o   one-cycle completion pulse
//            d_o      difference (a - b - bin) mod 2^WIDTH
//            bout_o   borrow-out, 1 iff a < b + bin
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;

  // One full-subtractor slice working on the current LSBs.
  logic             x_w;
  logic             y_w;
  logic             diff_w;
  logic             borrow_d;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    x_w      = a_q[0];
    y_w      = b_q[0];
    diff_w   = x_w ^ y_w ^ borrow_q;
    borrow_d = (~x_w & y_w) | (~(x_w ^ y_w) & borrow_q);
    // New bit enters at the MSB; after WIDTH shifts bit 0 lands at position 0.
    res_d    = {diff_w, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            borrow_q <= bin_i;
            res_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          res_q    <= res_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            d_q     <= res_d;
            bout_q  <= borrow_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign d_o    = d_q;
  assign bout_o = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub4.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub4
// Purpose  : Directed and exhaustive self-checking bench for serial_sub4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub4;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic       bin_i;
  logic       busy_o;
  logic       done_o;
  logic [3:0] d_o;
  logic       bout_o;
  logic       clk_run;

  int checks;
  int failures;

  serial_sub4 #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .d_o     (d_o),
    .bout_o  (bout_o)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done. Operand inputs are
  // scrambled right after acceptance to show they were captured.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output logic [4:0] res, output int lat, output int busy_cnt);
    @(negedge clk);
    a_i = a; b_i = b; bin_i = bin; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i = ~a; b_i = ~b; bin_i = ~bin;
    busy_cnt = busy_o ? 1 : 0;
    lat = 0;
    while (!done_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy_o) busy_cnt++;
    end
    res = {bout_o, d_o};
  endtask

  logic [4:0] res;
  logic [4:0] exp5;
  int lat;
  int bcnt;
  int pulses;

  initial begin
    checks   = 0;
    failures = 0;
    clk_run  = 1'b0;
    start_i  = 1'b0;
    a_i = '0; b_i = '0; bin_i = 1'b0;

    // 1. reset with no clock running
    rst = 1'b1;
    #3;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_d",    d_o,    0);
    check("reset_bout", bout_o, 0);
    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 2. basic subtraction
    run_op(4'd9, 4'd3, 1'b0, res, lat, bcnt);
    check("basic_lat",  lat, 4);
    check("basic_busy", bcnt, 4);
    check("basic_res",  res, {1'b0, 4'd6});
    @(posedge clk); #1;
    check("basic_done_pulse_end", done_o, 0);
    check("basic_d_hold", d_o, 6);
    run_op(4'd9, 4'd3, 1'b1, res, lat, bcnt);
    check("basic_bin_res", res, {1'b0, 4'd5});

    // 3. underflow and boundaries
    run_op(4'd3, 4'd12, 1'b0, res, lat, bcnt);
    check("uflow_3_12", res, {1'b1, 4'd7});
    run_op(4'd0, 4'd0, 1'b1, res, lat, bcnt);
    check("uflow_0_0_1", res, {1'b1, 4'd15});
    run_op(4'd15, 4'd0, 1'b0, res, lat, bcnt);
    check("max_0_0", res, {1'b0, 4'd15});
    run_op(4'd10, 4'd10, 1'b0, res, lat, bcnt);
    check("equal", res, {1'b0, 4'd0});

    // 4. start ignored while busy, then back-to-back from the done cycle
    @(negedge clk);
    a_i = 4'd12; b_i = 4'd5; bin_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start_i = 1'b1; a_i = 4'd1; b_i = 4'd1;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) pulses++;
    end
    check("ign_done_pulses", pulses, 1);
    check("ign_res", {bout_o, d_o}, {1'b0, 4'd7});
    start_i = 1'b1; a_i = 4'd6; b_i = 4'd3; bin_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("b2b_busy", busy_o, 1);
    check("b2b_d_hold", d_o, 7);
    lat = 0;
    while (!done_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat", lat, 4);
    check("b2b_res", {bout_o, d_o}, {1'b0, 4'd2});

    // 5. reset mid-operation at cnt==2
    @(negedge clk);
    a_i = 4'd9; b_i = 4'd3; bin_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_d",    d_o,    0);
    check("midrst_bout", bout_o, 0);
    check("midrst_done", done_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_o || busy_o) pulses++;
    end
    check("midrst_no_activity", pulses, 0);
    run_op(4'd9, 4'd3, 1'b0, res, lat, bcnt);
    check("midrst_fresh", res, {1'b0, 4'd6});

    // 6. exhaustive against a 5-bit two's complement model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          exp5 = 5'(a - b - c);
          run_op(4'(a), 4'(b), 1'(c), res, lat, bcnt);
          check($sformatf("exh_%0d_%0d_%0d", a, b, c), res, exp5);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
